// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared constants, switch vector type and per-bit debounce state encoding
package sw_debounce_pkg;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int SW_WIDTH_DEF = 10;
  localparam int DEBOUNCE_CYCLES_SIM = 4;
  typedef logic [SW_WIDTH_DEF-1:0] sw_vec_t;
  typedef enum logic {ST_STABLE, ST_PENDING} db_state_t;
endpackage

// File: rtl/sw_debounce_bit.sv
// debounce_bit: one switch bit; ports clk, reset, i_raw -> o_clean level plus o_rise/o_fall flip strobes for the edge on which o_clean flips
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic r_sync1, r_sync2, r_clean;
  logic [CNT_W-1:0] r_cnt;
  db_state_t w_state;
  logic w_flip;
  always_comb begin
    w_state = (r_sync2 != r_clean) ? ST_PENDING : ST_STABLE;
    w_flip = (w_state == ST_PENDING) && (r_cnt == TERM);
  end
  assign o_clean = r_clean;
  assign o_rise = w_flip & r_sync2;
  assign o_fall = w_flip & ~r_sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_clean <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_clean <= w_flip ? r_sync2 : r_clean;
      r_cnt <= (w_state == ST_STABLE || w_flip) ? '0 : r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: debounced switches; ports clk, reset, sw_raw -> sw_clean, sw_rise, sw_change (sw_fall added when SW_FALL_EDGE_EN is defined)
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
`ifdef SW_FALL_EDGE_EN
  output logic [WIDTH-1:0] sw_fall,
`endif
  output logic             sw_change
);
  logic [WIDTH-1:0] w_rise, w_fall, r_rise;
  logic r_change;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk(clk),
      .reset(reset),
      .i_raw(sw_raw[i]),
      .o_clean(sw_clean[i]),
      .o_rise(w_rise[i]),
      .o_fall(w_fall[i])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise <= '0;
      r_change <= 1'b0;
    end else begin
      r_rise <= w_rise;
      r_change <= |(w_rise | w_fall);
    end
  end
  assign sw_rise = r_rise;
  assign sw_change = r_change;
`ifdef SW_FALL_EDGE_EN
  logic [WIDTH-1:0] r_fall;
  always_ff @(posedge clk) begin
    if (reset) r_fall <= '0;
    else r_fall <= w_fall;
  end
  assign sw_fall = r_fall;
`endif
endmodule
